// File: rtl/pwm_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pattern_sequencer
// Description : Single-clock duty sequencer for the LED PWM bank; a prescaler
//               paces steps of an idle/chase/breathe/comet pattern FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_pattern_sequencer #(
    parameter int CHANNELS = 16,
    parameter int DUTY_W   = 8,
    parameter int TICK_DIV = 1_000_000,
    parameter int STEP     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    output logic [CHANNELS*DUTY_W-1:0]   duty_out,
    output logic                         step_pulse,
    output logic [1:0]                   active_mode
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [DUTY_W-1:0] c_MAX       = '1;
    localparam logic [DUTY_W:0]   c_MAX_EXT   = {1'b0, c_MAX};
    localparam logic [DUTY_W:0]   c_STEP      = (DUTY_W+1)'(STEP);
    localparam logic [PW-1:0]     c_LAST_POS  = PW'(CHANNELS - 1);
    localparam logic [CW-1:0]     c_TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] c_MODE_IDLE    = 2'b00;
    localparam logic [1:0] c_MODE_CHASE   = 2'b01;
    localparam logic [1:0] c_MODE_BREATHE = 2'b10;
    localparam logic [1:0] c_MODE_COMET   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_CHASE   = 3'd2,
        S_BREATHE = 3'd3,
        S_COMET   = 3'd4
    } state_t;

    state_t            r_state;
    logic [1:0]        r_active_mode;
    logic [CW-1:0]     r_presc;
    logic [PW-1:0]     r_pos;
    logic [DUTY_W-1:0] r_level;
    logic              r_dir;
    logic              r_step_pulse;
    logic [DUTY_W-1:0] r_duty [CHANNELS];

    logic [PW-1:0]     w_pos_inc;
    logic [DUTY_W:0]   w_level_sum;
    logic [DUTY_W-1:0] w_level_next;
    logic              w_dir_next;
    logic              w_tick;
    state_t            w_target;
    logic [DUTY_W-1:0] w_step_duty [CHANNELS];

    assign w_pos_inc   = (r_pos == c_LAST_POS) ? '0 : r_pos + PW'(1);
    assign w_level_sum = {1'b0, r_level} + c_STEP;
    assign w_tick      = (r_presc == c_TICK_LAST);

    // Breathe arithmetic is one bit wider so the top clamp can never wrap.
    always_comb begin
        w_level_next = r_level;
        w_dir_next   = r_dir;
        if (!r_dir) begin
            if (w_level_sum >= c_MAX_EXT) begin
                w_level_next = c_MAX;
                w_dir_next   = 1'b1;
            end else begin
                w_level_next = w_level_sum[DUTY_W-1:0];
            end
        end else begin
            if ({1'b0, r_level} <= c_STEP) begin
                w_level_next = '0;
                w_dir_next   = 1'b0;
            end else begin
                w_level_next = r_level - c_STEP[DUTY_W-1:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_step_duty[i] = '0;
            case (r_state)
                S_CHASE:   w_step_duty[i] = (PW'(i) == w_pos_inc) ? c_MAX : '0;
                S_BREATHE: w_step_duty[i] = w_level_next;
                S_COMET:   w_step_duty[i] = (PW'(i) == w_pos_inc) ? c_MAX : (r_duty[i] >> 1);
                default:   w_step_duty[i] = '0;
            endcase
        end
    end

    always_comb begin
        case (r_active_mode)
            c_MODE_CHASE:   w_target = S_CHASE;
            c_MODE_BREATHE: w_target = S_BREATHE;
            c_MODE_COMET:   w_target = S_COMET;
            default:        w_target = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_active_mode <= c_MODE_IDLE;
            r_presc       <= '0;
            r_pos         <= c_LAST_POS;
            r_level       <= '0;
            r_dir         <= 1'b0;
            r_step_pulse  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            r_step_pulse <= 1'b0;
            if (!enable) begin
                r_state       <= S_IDLE;
                r_active_mode <= c_MODE_IDLE;
                r_presc       <= '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_duty[i] <= '0;
                end
            end else if (mode != r_active_mode) begin
                // Mode changes win over any step due on this edge.
                r_state       <= S_CLEAR;
                r_active_mode <= mode;
                r_presc       <= '0;
                r_pos         <= c_LAST_POS;
                r_level       <= '0;
                r_dir         <= 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_duty[i] <= '0;
                end
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        r_state <= w_target;
                        r_presc <= '0;
                    end
                    S_CHASE, S_BREATHE, S_COMET: begin
                        if (w_tick) begin
                            r_presc      <= '0;
                            r_step_pulse <= 1'b1;
                            for (int i = 0; i < CHANNELS; i++) begin
                                r_duty[i] <= w_step_duty[i];
                            end
                            if (r_state == S_BREATHE) begin
                                r_level <= w_level_next;
                                r_dir   <= w_dir_next;
                            end else begin
                                r_pos <= w_pos_inc;
                            end
                        end else begin
                            r_presc <= r_presc + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_presc <= '0;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
            assign duty_out[g*DUTY_W +: DUTY_W] = r_duty[g];
        end
    endgenerate

    assign step_pulse  = r_step_pulse;
    assign active_mode = r_active_mode;

endmodule
`default_nettype wire

// File: tb/tb_pwm_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_pattern_sequencer
// Description : Randomized self-checking bench for pwm_pattern_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_pattern_sequencer;

    localparam int CHANNELS = 16;
    localparam int DUTY_W   = 8;
    localparam int TICK_DIV = 4;
    localparam int STEP     = 64;
    localparam int MAXV     = 255;
    localparam int VW       = CHANNELS * DUTY_W;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode   = 2'b00;
    logic [VW-1:0] duty_out;
    logic          step_pulse;
    logic [1:0]    active_mode;

    int         n_checks   = 0;
    int         n_fail     = 0;
    logic [1:0] cur_active = 2'b00;

    pwm_pattern_sequencer #(
        .CHANNELS (CHANNELS),
        .DUTY_W   (DUTY_W),
        .TICK_DIV (TICK_DIV),
        .STEP     (STEP)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .duty_out    (duty_out),
        .step_pulse  (step_pulse),
        .active_mode (active_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Breathe level after k steps, walking the triangle rule from level 0 going up.
    function automatic int breathe_level(input int k);
        int lvl = 0;
        bit down = 1'b0;
        for (int s = 0; s < k; s++) begin
            if (!down) begin
                if (lvl + STEP >= MAXV) begin lvl = MAXV; down = 1'b1; end
                else lvl = lvl + STEP;
            end else begin
                if (lvl <= STEP) begin lvl = 0; down = 1'b0; end
                else lvl = lvl - STEP;
            end
        end
        return lvl;
    endfunction

    // Channel value after k steps of a pattern started from a cleared bank.
    function automatic int model_duty(input logic [1:0] m, input int k, input int ch);
        int d;
        if (k == 0) return 0;
        case (m)
            2'b01: return (ch == (k - 1) % CHANNELS) ? MAXV : 0;
            2'b10: return breathe_level(k);
            2'b11: begin
                d = (((k - 1 - ch) % CHANNELS) + CHANNELS) % CHANNELS;
                if ((k - d) < 1 || d >= DUTY_W) return 0;
                return MAXV >> d;
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [VW-1:0] model_vec(input logic [1:0] m, input int k);
        logic [VW-1:0] v = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            v[ch*DUTY_W +: DUTY_W] = DUTY_W'(model_duty(m, k, ch));
        end
        return v;
    endfunction

    // Selects mode m (differing from the running mode) and checks n edges from the CLEAR edge on.
    task automatic run_segment(input logic [1:0] m, input int n, input string tag);
        logic [VW-1:0] exp_vec;
        logic          exp_pulse;
        int            k;
        @(negedge clk);
        enable = 1'b1;
        mode   = m;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            k         = (t >= 1) ? (t - 1) / TICK_DIV : 0;
            exp_pulse = (m != 2'b00) && (t > 1) && ((t - 1) % TICK_DIV == 0);
            exp_vec   = model_vec(m, k);
            n_checks++;
            if (duty_out !== exp_vec) begin
                n_fail++;
                $display("FAIL %s duty t=%0d k=%0d: got %h expected %h", tag, t, k, duty_out, exp_vec);
            end
            n_checks++;
            if (step_pulse !== exp_pulse) begin
                n_fail++;
                $display("FAIL %s step_pulse t=%0d: got %b expected %b", tag, t, step_pulse, exp_pulse);
            end
            n_checks++;
            if (active_mode !== m) begin
                n_fail++;
                $display("FAIL %s active_mode t=%0d: got %b expected %b", tag, t, active_mode, m);
            end
        end
        cur_active = m;
    endtask

    task automatic run_disabled(input int n, input string tag);
        @(negedge clk);
        enable = 1'b0;
        mode   = 2'($urandom_range(0, 3));
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (duty_out !== '0 || step_pulse !== 1'b0 || active_mode !== 2'b00) begin
                n_fail++;
                $display("FAIL %s disabled t=%0d: got duty=%h pulse=%b mode=%b expected 0/0/00",
                         tag, t, duty_out, step_pulse, active_mode);
            end
        end
        cur_active = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (duty_out !== '0 || step_pulse !== 1'b0 || active_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: got duty=%h pulse=%b mode=%b expected 0/0/00",
                     duty_out, step_pulse, active_mode);
        end
        enable = 1'b1;
        mode   = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (duty_out !== '0 || active_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: got duty=%h mode=%b expected 0/00", duty_out, active_mode);
        end
        mode = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        cur_active = 2'b00;
        run_segment(2'b00, 8, "idle_after_reset");
    endtask

    task automatic test_reset_mid_chase();
        run_segment(2'b01, 10 + $urandom_range(0, 30), "chase_pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (duty_out !== '0 || step_pulse !== 1'b0 || active_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: got duty=%h pulse=%b mode=%b expected 0/0/00",
                     duty_out, step_pulse, active_mode);
        end
        @(negedge clk);
        mode = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        cur_active = 2'b00;
        run_segment(2'b00, 8, "idle_after_mid_reset");
    endtask

    task automatic test_chase();
        run_segment(2'b01, 4 * 17 + 2, "chase");
        n_checks++;
        if (duty_out !== {{(CHANNELS-1){8'h00}}, 8'hFF}) begin
            n_fail++;
            $display("FAIL chase_wrap: got %h expected only ch0=ff", duty_out);
        end
    endtask

    task automatic test_breathe();
        int lvl_tbl [9] = '{64, 128, 192, 255, 191, 127, 63, 0, 64};
        int waited;
        @(negedge clk);
        enable = 1'b1;
        mode   = 2'b10;
        for (int s = 0; s < 9; s++) begin
            waited = 0;
            do begin
                @(posedge clk);
                #1;
                waited++;
            end while (step_pulse !== 1'b1 && waited < 12);
            n_checks++;
            if (waited != ((s == 0) ? 6 : 4)) begin
                n_fail++;
                $display("FAIL breathe_spacing step %0d: got %0d cycles expected %0d",
                         s, waited, (s == 0) ? 6 : 4);
            end
            n_checks++;
            if (duty_out !== {CHANNELS{DUTY_W'(lvl_tbl[s])}}) begin
                n_fail++;
                $display("FAIL breathe_level step %0d: got %h expected all %0d", s, duty_out, lvl_tbl[s]);
            end
        end
        cur_active = 2'b10;
    endtask

    task automatic test_comet();
        logic [VW-1:0] exp3;
        exp3 = '0;
        exp3[0 +: 8]  = 8'd63;
        exp3[8 +: 8]  = 8'd127;
        exp3[16 +: 8] = 8'd255;
        run_segment(2'b11, 14, "comet_short");
        n_checks++;
        if (duty_out !== exp3) begin
            n_fail++;
            $display("FAIL comet_three_steps: got %h expected %h", duty_out, exp3);
        end
        run_segment(2'b01, 3, "comet_gap");
        run_segment(2'b11, 4 * 18 + 2, "comet_long");
    endtask

    task automatic test_switch_on_step();
        // Last checked edge sits one cycle before a chase step edge.
        run_segment(2'b01, 4 * $urandom_range(2, 5) + 1, "switch_chase");
        run_segment(2'b10, 12, "switch_breathe");
    endtask

    task automatic test_disable();
        run_disabled(2, "disable_pre");
        run_segment(2'b10, 4 * $urandom_range(2, 5) + 1 + $urandom_range(0, 1), "disable_breathe");
        run_disabled(1 + $urandom_range(0, 5), "disable");
        run_segment(2'b10, 8, "reenable_breathe");
        n_checks++;
        if (duty_out !== {CHANNELS{8'd64}}) begin
            n_fail++;
            $display("FAIL reenable_level: got %h expected all 64", duty_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] m;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                run_disabled(1 + $urandom_range(0, 5), "b2b_disable");
            end else begin
                m = 2'((32'(cur_active) + $urandom_range(1, 3)) % 4);
                run_segment(m, 1 + $urandom_range(0, 44), "b2b_mode");
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_chase();
        test_chase();
        test_breathe();
        test_comet();
        test_switch_on_step();
        test_disable();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
